// File: rtl/proto_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proto_pkg
//  Purpose  : Shared types and constants for the debug register-dump path.
//             Holds the dump FSM state type, the dump header byte and the
//             default UART bit period (100 MHz clock, 115200 baud).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package proto_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } dump_state_t;

  localparam logic [7:0] DUMP_HEADER               = 8'hA5;
  localparam int         UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_byte
//  Purpose  : 8N1 UART byte serializer. A one-cycle load captures a byte and
//             emits start bit, 8 data bits LSB first, and one stop bit, each
//             held CLKS_PER_BIT cycles.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             load            - capture data and begin a frame (ignored if busy)
//             data[7:0]       - byte to send
//             busy            - frame in progress
//             frame_end       - high in the last cycle of the stop bit
//             tx              - serial line, idle high
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_byte
  import proto_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       frame_end,
  output logic       tx
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  dump_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             baud_tick;

  assign baud_tick = (baud_cnt == CNT_LAST);
  assign busy      = (state != IDLE);
  // Lets the sequencer issue the next load on the same edge the stop bit
  // ends, so consecutive frames are separated only by the LOAD cycle.
  assign frame_end = (state == STOP) && baud_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shreg    <= data;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_tx
//  Purpose  : Debug readout. On a start pulse, sends a header byte followed by
//             every register-file entry (index 0..NUM_REGS-1) as 8N1 frames.
//             Reads through a shared combinational read port; never writes.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             start           - dump request, sampled only when idle
//             rd_addr         - register file read address (= current index)
//             rd_data         - register file read data (combinational)
//             busy            - dump in progress, through the DONE cycle
//             done            - one-cycle pulse after the last stop bit
//             tx              - UART line, idle high
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_tx
  import proto_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int NUM_REGS     = 16,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic              hdr;
  logic              ser_load;
  logic              ser_busy;
  logic              ser_frame_end;
  logic [7:0]        ser_data;

  assign rd_addr  = idx;
  // The register value is captured by the serializer at the edge ending LOAD.
  assign ser_data = hdr ? DUMP_HEADER : rd_data;
  assign ser_load = (state == LOAD) && !ser_busy;

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .data      (ser_data),
    .busy      (ser_busy),
    .frame_end (ser_frame_end),
    .tx        (tx)
  );

  // START here stands for "frame in flight"; the serializer tracks the
  // detailed START/DATA/STOP phases itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      hdr   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= '0;
            hdr   <= 1'b1;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= START;
        end
        START: begin
          if (ser_frame_end) begin
            if (hdr) begin
              hdr   <= 1'b0;
              state <= LOAD;
            end else if (idx < LAST_IDX) begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
